// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer with timeout, retry and lock-loss handling
// Optional lock-loss counter enabled by defining PLL_LOSS_COUNTER_EN; otherwise loss_count is tied to 0.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 74250,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int CNT_W          = 8
) (
    input  logic             clk_74a,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             resync_req,
    output logic             pll_rst,
    output logic             sys_reset_n,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int T_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > STABLE_CYCLES) ? T_MAX_A : STABLE_CYCLES;
    localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Timer holds the number of completed cycles in the current state.
    localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STAB_LAST = TIMER_W'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         sync_q, sync_d;
    logic               lk;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_reset_n_q, sys_reset_n_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;
    logic [CNT_W-1:0]   retry_q, retry_d;
    logic [CNT_W-1:0]   retry_sat;

    assign lk        = sync_q[1];
    assign retry_sat = (&retry_q) ? retry_q : retry_q + CNT_W'(1);

    always_comb begin
        sync_d  = {sync_q[0], pll_locked};
        state_d = state_q;
        retry_d = retry_q;

        case (state_q)
            ST_PLL_RESET: begin
                if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TMO_LAST) begin
                    retry_d = retry_sat;
                    if (MAX_RETRIES != 0 && 32'(retry_sat) >= MAX_RETRIES)
                        state_d = ST_FAIL;
                    else
                        state_d = ST_PLL_RESET;
                end
            end
            ST_STABLE: begin
                if (!lk)
                    state_d = ST_WAIT_LOCK;
                else if (timer_q == STAB_LAST)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lk) state_d = ST_PLL_RESET;
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: state_d = ST_PLL_RESET;
        endcase

        // Software re-sequence overrides any transition decided above.
        if (resync_req) begin
            state_d = ST_PLL_RESET;
            retry_d = retry_q;
        end

        if (resync_req || state_d != state_q || state_q == ST_RUN || state_q == ST_FAIL)
            timer_d = '0;
        else
            timer_d = timer_q + TIMER_W'(1);

        pll_rst_d     = (state_d == ST_PLL_RESET);
        sys_reset_n_d = (state_d == ST_RUN);
        ready_d       = (state_d == ST_RUN);
        fail_d        = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk_74a) begin
        if (!reset_n) begin
            state_q       <= ST_PLL_RESET;
            timer_q       <= '0;
            sync_q        <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
            retry_q       <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sync_q        <= sync_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            ready_q       <= ready_d;
            fail_q        <= fail_d;
            retry_q       <= retry_d;
        end
    end

`ifdef PLL_LOSS_COUNTER_EN
    logic [CNT_W-1:0] loss_q, loss_d;

    // A loss coinciding with a resync request is not counted.
    always_comb begin
        loss_d = loss_q;
        if (!resync_req && state_q == ST_RUN && !lk && !(&loss_q))
            loss_d = loss_q + CNT_W'(1);
    end

    always_ff @(posedge clk_74a) begin
        if (!reset_n) loss_q <= '0;
        else          loss_q <= loss_d;
    end

    assign loss_count = loss_q;
`else
    assign loss_count = '0;
`endif

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Single-clock controller on the 74.25 MHz reference clock that drives the system PLL's reset input and consumes its asynchronous locked output. Sequences PLL reset, waits for lock with timeout/retry, qualifies lock stability, then releases a system reset for the PLL-clocked logic. Watches for lock loss and for software re-sequence requests, and reports status to the bridge/debug registers.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT, 74250, cycles to wait for synchronized lock before retrying (~1 ms)
STABLE_CYCLES, 1024, cycles lock must stay continuously high before release (>=1)
MAX_RETRIES, 7, retries before entering FAIL; 0 = retry forever
CNT_W, 8, width of retry/loss status counters

Ports:
clk_74a  input  1  reference clock; also the PLL refclk
reset_n  input  1  synchronous active-low reset
pll_locked  input  1  PLL locked, asynchronous to clk_74a
resync_req  input  1  single-cycle request to re-sequence the PLL
pll_rst  output  1  to PLL rst, active high
sys_reset_n  output  1  active-low reset for PLL-clocked domains
ready  output  1  high in RUN
fail  output  1  high in FAIL (retries exhausted)
retry_count  output  CNT_W  saturating count of lock-timeout retries since reset_n
loss_count  output  CNT_W  saturating count of lock losses in RUN (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at a clk_74a edge): state=PLL_RESET, timer=0, pll_rst=1, sys_reset_n=0, ready=0, fail=0, retry_count=0, loss_count=0, synchronizer flops=0.
- pll_locked passes a 2-flop synchronizer; lk = second flop. All decisions use lk (2-cycle latency).
- All outputs registered. One timer, cleared on every state transition.
- PLL_RESET: pll_rst=1. Exit to WAIT_LOCK after exactly PLL_RST_CYCLES cycles; pll_rst low from the first WAIT_LOCK cycle.
- WAIT_LOCK: pll_rst=0. lk=1 -> STABLE. Timer reaches LOCK_TIMEOUT with lk=0 -> retry_count++ (saturating); if MAX_RETRIES!=0 and the new count reaches MAX_RETRIES -> FAIL, else -> PLL_RESET. If lk rises in the same cycle the timeout fires, lk wins (-> STABLE).
- STABLE: lk=0 at any point -> WAIT_LOCK with a fresh timeout (no retry increment). lk=1 for STABLE_CYCLES consecutive cycles -> RUN.
- RUN: sys_reset_n=1, ready=1 from the first RUN cycle. lk=0 -> sys_reset_n=0 and ready=0 on the next edge, loss_count++ (saturating), -> PLL_RESET.
- FAIL: pll_rst=0, sys_reset_n=0, fail=1. Leave only by resync_req or reset_n.
- resync_req=1 in any state -> PLL_RESET, sys_reset_n=0, ready=0, fail=0. Counters hold their values. Takes priority over every other transition in the same cycle, including lock loss (loss_count not incremented then).
- sys_reset_n is 1 only in RUN; glitch-free, because it is a flop.
- retry_count and loss_count clear only on reset_n; they saturate at all-ones and never wrap.
- reset_n asserted mid-sequence: immediate return to reset values on that edge. pll_rst=1 on the following cycle, so the PLL is always re-reset.

Optional Feature:
PLL_LOSS_COUNTER_EN
- Defined: loss_count operates as described.
- Undefined: the loss counter logic is removed and loss_count is tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset release with pll_locked tied 1 (PLL_RST_CYCLES=16, STABLE_CYCLES=1024) -> pll_rst high 16 cycles; sys_reset_n/ready rise exactly 16+2+1024 cycles later (±1 per documented boundary); retry_count=0.
- pll_locked held 0 (LOCK_TIMEOUT=100, MAX_RETRIES=3) -> three pll_rst pulses of 16 cycles each; retry_count=3; fail=1; sys_reset_n stays 0. Then resync_req -> fail=0 and pll_rst=1 next cycle.
- pll_locked drops for 3 cycles mid-STABLE -> state goes back to WAIT_LOCK; stability count restarts; no retry increment; RUN entered 1024 cycles after lock returns.
- In RUN, drop pll_locked -> sys_reset_n=0 within 3 cycles of the drop; loss_count 0->1; full re-sequence follows. With PLL_LOSS_COUNTER_EN undefined, loss_count stays 0.
- resync_req and lock loss in the same RUN cycle -> PLL_RESET; loss_count unchanged. Also: force 300 losses with CNT_W=8 -> loss_count saturates at 255.
- Assert reset_n during WAIT_LOCK and during RUN -> all outputs at reset values on the next edge; counters zeroed.
